uart_rx_ext: RTL and testbench

Configurable UART receiver, the successor to the basic 8N1 receiver. It adds runtime-selectable character length (5–8 bits), parity (none/even/odd) and one or two stop bits. It validates the start bit, detects parity errors, framing errors and line break, and delivers each character through a valid/ready holding register with overrun reporting. It sits between the pad-side rx line and a bus-side UART core or FIFO.

---
 rtl/uart_rx_ext.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// Configurable UART receiver: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits,
// with break detection and a single-entry holding register with overrun reporting.
module uart_rx_ext #(
    parameter int DIV_WIDTH     = 8,
    parameter int GLITCH_FILTER = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [1:0]           cfg_bits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic [7:0]           out_data,
    output logic                 out_perr,
    output logic                 out_ferr,
    output logic                 out_brk,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovr_stb,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_BRKWAIT = 3'd5
    } state_t;

    localparam int FCW = (GLITCH_FILTER > 1) ? $clog2(GLITCH_FILTER) : 1;

    logic           sync1, sync2;
    logic           rx_val, rx_fall;
    logic [FCW-1:0] flt_cnt;

    state_t               state;
    logic [DIV_WIDTH:0]   cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic [1:0]           nbits_q;
    logic [1:0]           par_q;
    logic                 stop2_q;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic                 par_acc;
    logic                 all_zero;
    logic                 perr_q, ferr_q, brk_q;
    logic                 stop_second;

    logic tick;
    logic frame_ferr, frame_brk;

    // Counter MSB is the borrow: it marks a sample cycle.
    assign tick       = cnt[DIV_WIDTH];
    assign frame_ferr = ferr_q | ~rx_val;
    assign frame_brk  = stop_second ? brk_q : (all_zero & ~rx_val);
    assign dbg_state  = state;

    // rx_val only follows the synchronized line once it has disagreed for
    // GLITCH_FILTER consecutive cycles; rx_fall marks the 1->0 update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_val  <= 1'b1;
            rx_fall <= 1'b0;
            flt_cnt <= '0;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            rx_fall <= 1'b0;
            if (sync2 == rx_val) begin
                flt_cnt <= '0;
            end else if (GLITCH_FILTER <= 1 || flt_cnt == FCW'(GLITCH_FILTER - 1)) begin
                rx_val  <= sync2;
                rx_fall <= rx_val;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FCW'(1);
            end
        end
    end

    // Output handshake: a character moves to the consumer on any cycle where
    // out_valid & out_ready; a frame completing while out_valid & ~out_ready is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            div_q       <= '0;
            nbits_q     <= '0;
            par_q       <= '0;
            stop2_q     <= 1'b0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            all_zero    <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            stop_second <= 1'b0;
            out_data    <= '0;
            out_perr    <= 1'b0;
            out_ferr    <= 1'b0;
            out_brk     <= 1'b0;
            out_valid   <= 1'b0;
            ovr_stb     <= 1'b0;
        end else begin
            ovr_stb <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (state == S_START || state == S_DATA || state == S_PARITY || state == S_STOP)
                cnt <= tick ? {1'b0, div_q} : cnt - (DIV_WIDTH+1)'(1);

            case (state)
                S_IDLE: begin
                    if (rx_fall) begin
                        state   <= S_START;
                        div_q   <= div;
                        nbits_q <= cfg_bits;
                        par_q   <= cfg_parity;
                        stop2_q <= cfg_stop2;
                        // First tick lands at mid start bit, (div>>1)+1 cycles after rx_fall.
                        cnt     <= {1'b0, div >> 1} - (DIV_WIDTH+1)'(1);
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_val) begin
                            state <= S_IDLE;
                        end else begin
                            state       <= S_DATA;
                            bit_idx     <= '0;
                            shreg       <= '0;
                            par_acc     <= 1'b0;
                            all_zero    <= 1'b1;
                            perr_q      <= 1'b0;
                            ferr_q      <= 1'b0;
                            brk_q       <= 1'b0;
                            stop_second <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg[bit_idx] <= rx_val;
                        par_acc        <= par_acc ^ rx_val;
                        all_zero       <= all_zero & ~rx_val;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == ({1'b0, nbits_q} + 3'd4))
                            state <= par_q[1] ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        perr_q   <= par_acc ^ rx_val ^ par_q[0];
                        all_zero <= all_zero & ~rx_val;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (stop2_q && !stop_second) begin
                            ferr_q      <= frame_ferr;
                            brk_q       <= frame_brk;
                            stop_second <= 1'b1;
                        end else begin
                            if (!out_valid || out_ready) begin
                                out_data  <= shreg;
                                out_perr  <= perr_q;
                                out_ferr  <= frame_ferr;
                                out_brk   <= frame_brk;
                                out_valid <= 1'b1;
                            end else begin
                                ovr_stb <= 1'b1;
                            end
                            state <= rx_val ? S_IDLE : S_BRKWAIT;
                        end
                    end
                end
                S_BRKWAIT: begin
                    if (rx_val)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext at div=14 (16-clock bit period), input filter of 2.
module tb_uart_rx_ext;

    localparam int P = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] div;
    logic [1:0] cfg_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic [7:0] out_data;
    logic       out_perr, out_ferr, out_brk, out_valid, out_ready, ovr_stb;
    logic [2:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rise_cyc = 0;
    int ovr_cnt = 0;
    logic prev_v = 1'b0;
    logic [10:0] got_q[$];
    int t0;

    uart_rx_ext #(.DIV_WIDTH(8), .GLITCH_FILTER(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .div(div),
        .cfg_bits(cfg_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .out_data(out_data), .out_perr(out_perr), .out_ferr(out_ferr), .out_brk(out_brk),
        .out_valid(out_valid), .out_ready(out_ready), .ovr_stb(ovr_stb), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: accepted characters packed as {perr, ferr, brk, data}
    always @(negedge clk) begin
        prev_v <= out_valid;
        if (out_valid && !prev_v) rise_cyc <= cyc;
        if (ovr_stb) ovr_cnt <= ovr_cnt + 1;
        if (out_valid && out_ready && !rst)
            got_q.push_back({out_perr, out_ferr, out_brk, out_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_raw(input logic [11:0] bits, input int len, output int start_cyc);
        @(posedge clk); #1;
        start_cyc = cyc;
        for (int i = 0; i < len; i++) begin
            rx = bits[i];
            repeat (P) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic set_cfg(input logic [1:0] b, input logic [1:0] p, input logic s2);
        @(posedge clk); #1;
        cfg_bits = b; cfg_parity = p; cfg_stop2 = s2;
    endtask

    task automatic wait_got(input string tag, input int n);
        for (int i = 0; i < 400 && got_q.size() < n; i++) @(negedge clk);
        check(tag, got_q.size(), n);
    endtask

    task automatic pop_check(input string tag, input logic [10:0] exp);
        logic [10:0] g;
        g = (got_q.size() > 0) ? got_q.pop_front() : 11'h7ff;
        check(tag, {21'b0, g}, {21'b0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx = 1'b1; div = 8'd14; out_ready = 1'b0;
        cfg_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst flags", {out_perr, out_ferr, out_brk, ovr_stb}, 0);
        check("rst state", dbg_state, 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("idle state", dbg_state, 0);
        check("idle valid", out_valid, 0);

        // 8N1 0xA5, held with out_ready low
        set_cfg(2'd3, 2'b00, 1'b0);
        send_raw({3'b111, 8'hA5, 1'b0}, 10, t0);
        check("8n1 latency", rise_cyc - t0, 4 + 8 + 9 * P + 1);
        check("8n1 data", out_data, 8'hA5);
        check("8n1 flags", {out_perr, out_ferr, out_brk}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold valid", out_valid, 1);
            check("hold data", out_data, 8'hA5);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("hs clears valid", out_valid, 0);
        pop_check("8n1 accepted", 11'h0A5);
        got_q.delete();

        // 7E1 0x41 with wrong parity bit, then the same frame in odd mode
        set_cfg(2'd2, 2'b10, 1'b0);
        send_raw({2'b11, 1'b1, 1'b1, 7'h41, 1'b0}, 10, t0);
        wait_got("7e1 count", 1);
        pop_check("7e1 perr", 11'h441);
        set_cfg(2'd2, 2'b11, 1'b0);
        send_raw({2'b11, 1'b1, 1'b1, 7'h41, 1'b0}, 10, t0);
        wait_got("7o1 count", 1);
        pop_check("7o1 ok", 11'h041);

        // 5N2 0x1F with second stop bit 0
        set_cfg(2'd0, 2'b00, 1'b1);
        send_raw({4'b1111, 1'b0, 1'b1, 5'h1F, 1'b0}, 8, t0);
        check("5n2 brkwait", dbg_state, 5);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("5n2 idle", dbg_state, 0);
        wait_got("5n2 count", 1);
        pop_check("5n2 ferr", 11'h21F);

        // 5-clock low glitch, then 0x3C
        set_cfg(2'd3, 2'b00, 1'b0);
        @(posedge clk); #1; rx = 1'b0;
        repeat (5) @(posedge clk);
        #1; rx = 1'b1;
        check("glitch start", dbg_state, 1);
        repeat (9) @(posedge clk);
        #1;
        check("glitch idle", dbg_state, 0);
        check("glitch no valid", out_valid, 0);
        check("glitch no data", got_q.size(), 0);
        send_raw({3'b111, 8'h3C, 1'b0}, 10, t0);
        wait_got("3c count", 1);
        pop_check("3c data", 11'h03C);

        // line break for three frame times, then 0x55
        @(posedge clk); #1; rx = 1'b0;
        repeat (30 * P) @(posedge clk);
        #1;
        check("brk wait state", dbg_state, 5);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("brk idle", dbg_state, 0);
        check("brk one delivery", got_q.size(), 1);
        pop_check("brk frame", 11'h300);
        send_raw({3'b111, 8'h55, 1'b0}, 10, t0);
        wait_got("55 count", 1);
        pop_check("55 data", 11'h055);
        check("no ovr yet", ovr_cnt, 0);

        // overrun, then reset mid-frame
        @(posedge clk); #1; out_ready = 1'b0;
        send_raw({3'b111, 8'h11, 1'b0}, 10, t0);
        send_raw({3'b111, 8'h22, 1'b0}, 10, t0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovr held data", out_data, 8'h11);
        check("ovr held valid", out_valid, 1);
        check("ovr pulses", ovr_cnt, 1);
        send_raw({3'b111, 8'h33, 1'b0}, 5, t0);
        rx = 1'b1; rst = 1'b1;
        #2;
        check("arst valid", out_valid, 0);
        check("arst data", out_data, 0);
        check("arst flags", {out_perr, out_ferr, out_brk, ovr_stb}, 0);
        check("arst state", dbg_state, 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("post rst valid", out_valid, 0);
        check("post rst ovr", ovr_cnt, 1);
        check("post rst state", dbg_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
